// File: rtl/bus_quota_arbiter_if.sv
// Four-master request/grant bundle for bus_quota_arbiter.
// Handshake: each master pulls its req_ low and holds it low until its grnt_ goes low.
// The master keeps req_ low for as long as it wants the bus. It releases the bus by
// driving req_ high again. grnt_ is low for at most one master in any cycle.
//   m*_req_   master -> arbiter, active-low request
//   m*_grnt_  arbiter -> master, active-low registered grant
interface bus_quota_arbiter_if;
    logic m0_req_;
    logic m1_req_;
    logic m2_req_;
    logic m3_req_;
    logic m0_grnt_;
    logic m1_grnt_;
    logic m2_grnt_;
    logic m3_grnt_;

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_
    );

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_
    );
endinterface

// File: rtl/bus_quota_arbiter.sv
// Four-master round-robin bus arbiter with a hold quota. Between two owners there is
// always one dead cycle (HANDOVER).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus        request/grant bundle (slave side)
//   owner      current or last owner index
//   busy       high while a grant is active
//   preempt    one-cycle pulse in the first HANDOVER cycle after a quota expiry
//   hold_cnt   grant cycles elapsed for the current owner, saturating at HOLD_MAX-1
//   state_dbg  raw FSM state (0 IDLE, 1 GRANT, 2 HANDOVER)
module bus_quota_arbiter #(
    parameter int HOLD_W   = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    bus_quota_arbiter_if.slave bus,
    output logic [1:0]         owner,
    output logic               busy,
    output logic               preempt,
    output logic [HOLD_W-1:0]  hold_cnt,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        HANDOVER = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    state_t            state, state_n;
    logic [1:0]        owner_n;
    logic [HOLD_W-1:0] hold_n;
    logic              preempt_n;
    logic [3:0]        grnt_q, grnt_n;

    logic [3:0] req;
    logic [1:0] pick;
    logic       any_req;
    logic       owner_req;
    logic       others_req;

    assign req        = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
    assign any_req    = |req;
    assign owner_req  = req[owner];
    assign others_req = |(req & ~(4'b0001 << owner));

    // Search owner+1 .. owner+3 first and the current owner last. A preempted master
    // therefore wins only when nobody else is asking.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        pick  = owner;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = owner + 2'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // State register. The grants are registered from the next-state values, so each
    // grant pin comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 2'd3;
            hold_cnt <= '0;
            preempt  <= 1'b0;
            grnt_q   <= 4'hF;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            preempt  <= preempt_n;
            grnt_q   <= grnt_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        hold_n    = hold_cnt;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = GRANT;
                    owner_n = pick;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // A release takes precedence over a quota expiry in the same cycle.
                    state_n = others_req ? HANDOVER : IDLE;
                end else if (others_req && hold_cnt == HOLD_LAST) begin
                    state_n   = HANDOVER;
                    preempt_n = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            HANDOVER: begin
                if (any_req) begin
                    state_n = GRANT;
                    owner_n = pick;
                    hold_n  = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        grnt_n = (state_n == GRANT) ? ~(4'b0001 << owner_n) : 4'hF;
    end

    // Output decode.
    always_comb begin
        busy      = (state == GRANT);
        state_dbg = state;
    end

    assign bus.m0_grnt_ = grnt_q[0];
    assign bus.m1_grnt_ = grnt_q[1];
    assign bus.m2_grnt_ = grnt_q[2];
    assign bus.m3_grnt_ = grnt_q[3];

endmodule

// File: tb/tb_bus_quota_arbiter.sv
module tb_bus_quota_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_quota_arbiter_if if4 ();
    bus_quota_arbiter_if if2 ();

    logic [1:0] own4, own2, st4, st2;
    logic       busy4, busy2, pre4, pre2;
    logic [7:0] hold4, hold2;
    logic [3:0] g4, g2;

    assign g4 = {if4.m3_grnt_, if4.m2_grnt_, if4.m1_grnt_, if4.m0_grnt_};
    assign g2 = {if2.m3_grnt_, if2.m2_grnt_, if2.m1_grnt_, if2.m0_grnt_};

    bus_quota_arbiter #(.HOLD_W(8), .HOLD_MAX(4)) dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave), .owner(own4), .busy(busy4),
        .preempt(pre4), .hold_cnt(hold4), .state_dbg(st4)
    );

    bus_quota_arbiter #(.HOLD_W(8), .HOLD_MAX(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave), .owner(own2), .busy(busy2),
        .preempt(pre2), .hold_cnt(hold2), .state_dbg(st2)
    );

    // Advance one clock. Outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of v is mi_req_.
    task automatic set_req4(input logic [3:0] v);
        if4.m0_req_ = v[0]; if4.m1_req_ = v[1]; if4.m2_req_ = v[2]; if4.m3_req_ = v[3];
    endtask

    task automatic set_req2(input logic [3:0] v);
        if2.m0_req_ = v[0]; if2.m1_req_ = v[1]; if2.m2_req_ = v[2]; if2.m3_req_ = v[3];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_req4(4'hF);
        do_reset();
        checks++;
        if (g4 !== 4'hF || own4 !== 2'd3 || busy4 !== 1'b0 || pre4 !== 1'b0 ||
            hold4 !== 8'd0 || st4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state grnt=%b owner=%0d busy=%b pre=%b hold=%0d st=%0d want grnt=1111 owner=3 busy=0 pre=0 hold=0 st=0",
                     g4, own4, busy4, pre4, hold4, st4);
        end
        tick(); tick();
        set_req4(4'b1011);
        tick();
        checks++;
        if (g4 !== 4'b1011 || own4 !== 2'd2 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL first_grant_m2 grnt=%b owner=%0d busy=%b want grnt=1011 owner=2 busy=1", g4, own4, busy4);
        end
        set_req4(4'hF);
        tick();
        checks++;
        if (g4 !== 4'hF || own4 !== 2'd2 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL release_idle grnt=%b owner=%0d busy=%b want grnt=1111 owner=2 busy=0", g4, own4, busy4);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_req4(4'b1100);
        tick();
        checks++;
        if (g4 !== 4'b1110 || own4 !== 2'd0) begin
            errors++;
            $display("FAIL rr_m0_first grnt=%b owner=%0d want grnt=1110 owner=0", g4, own4);
        end
        set_req4(4'b1101);
        tick();
        checks++;
        if (g4 !== 4'hF || busy4 !== 1'b0 || pre4 !== 1'b0) begin
            errors++;
            $display("FAIL rr_dead_cycle grnt=%b busy=%b pre=%b want grnt=1111 busy=0 pre=0", g4, busy4, pre4);
        end
        tick();
        checks++;
        if (g4 !== 4'b1101 || own4 !== 2'd1 || hold4 !== 8'd0) begin
            errors++;
            $display("FAIL rr_m1_next grnt=%b owner=%0d hold=%0d want grnt=1101 owner=1 hold=0", g4, own4, hold4);
        end
        set_req4(4'hF);
        tick();
    endtask

    task automatic test_preempt();
        do_reset();
        set_req4(4'b0110);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (g4 !== 4'b1110 || hold4 !== 8'(i) || pre4 !== 1'b0) begin
                errors++;
                $display("FAIL quota_hold_%0d grnt=%b hold=%0d pre=%b want grnt=1110 hold=%0d pre=0", i, g4, hold4, pre4, i);
            end
        end
        tick();
        checks++;
        if (g4 !== 4'hF || pre4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL quota_preempt grnt=%b pre=%b busy=%b want grnt=1111 pre=1 busy=0", g4, pre4, busy4);
        end
        tick();
        checks++;
        if (g4 !== 4'b0111 || own4 !== 2'd3 || pre4 !== 1'b0) begin
            errors++;
            $display("FAIL quota_m3_grant grnt=%b owner=%0d pre=%b want grnt=0111 owner=3 pre=0", g4, own4, pre4);
        end
        set_req4(4'b1110);
        tick();
        checks++;
        if (g4 !== 4'hF || pre4 !== 1'b0) begin
            errors++;
            $display("FAIL quota_release_gap grnt=%b pre=%b want grnt=1111 pre=0", g4, pre4);
        end
        tick();
        checks++;
        if (g4 !== 4'b1110 || own4 !== 2'd0 || hold4 !== 8'd0) begin
            errors++;
            $display("FAIL quota_m0_regrant grnt=%b owner=%0d hold=%0d want grnt=1110 owner=0 hold=0", g4, own4, hold4);
        end
        set_req4(4'hF);
        tick();
    endtask

    task automatic test_expiry_with_release();
        do_reset();
        set_req4(4'b0110);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (hold4 !== 8'd3 || g4 !== 4'b1110) begin
            errors++;
            $display("FAIL exprel_setup hold=%0d grnt=%b want hold=3 grnt=1110", hold4, g4);
        end
        set_req4(4'b0111);
        tick();
        checks++;
        if (g4 !== 4'hF || pre4 !== 1'b0 || st4 !== 2'd2) begin
            errors++;
            $display("FAIL exprel_no_preempt grnt=%b pre=%b st=%0d want grnt=1111 pre=0 st=2", g4, pre4, st4);
        end
        tick();
        checks++;
        if (g4 !== 4'b0111 || own4 !== 2'd3) begin
            errors++;
            $display("FAIL exprel_m3 grnt=%b owner=%0d want grnt=0111 owner=3", g4, own4);
        end
        set_req4(4'hF);
        tick();
    endtask

    task automatic test_no_contention();
        int exp_h;
        do_reset();
        set_req4(4'b1101);
        tick();
        for (int i = 0; i < 100; i++) begin
            exp_h = (i < 3) ? i : 3;
            checks++;
            if (g4 !== 4'b1101 || pre4 !== 1'b0 || hold4 !== 8'(exp_h)) begin
                errors++;
                $display("FAIL lone_hold_%0d grnt=%b pre=%b hold=%0d want grnt=1101 pre=0 hold=%0d", i, g4, pre4, hold4, exp_h);
            end
            tick();
        end
        set_req4(4'hF);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        logic       exp_p;
        int         idx, ph;
        do_reset();
        set_req2(4'h0);
        tick();
        for (int c = 0; c < 24; c++) begin
            idx   = (c / 3) % 4;
            ph    = c % 3;
            exp_g = (ph == 2) ? 4'hF : ~(4'b0001 << idx);
            exp_p = (ph == 2);
            checks++;
            if (g2 !== exp_g || pre2 !== exp_p) begin
                errors++;
                $display("FAIL b2b_cycle_%0d grnt=%b pre=%b want grnt=%b pre=%b", c, g2, pre2, exp_g, exp_p);
            end
            tick();
        end
        set_req2(4'hF);
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        set_req4(4'b1101);
        tick();
        checks++;
        if (g4 !== 4'b1101 || own4 !== 2'd1) begin
            errors++;
            $display("FAIL midrst_setup grnt=%b owner=%0d want grnt=1101 owner=1", g4, own4);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (g4 !== 4'hF || busy4 !== 1'b0 || own4 !== 2'd3 || hold4 !== 8'd0) begin
            errors++;
            $display("FAIL midrst_cleared grnt=%b busy=%b owner=%0d hold=%0d want grnt=1111 busy=0 owner=3 hold=0",
                     g4, busy4, own4, hold4);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (g4 !== 4'b1101 || own4 !== 2'd1 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant grnt=%b owner=%0d busy=%b want grnt=1101 owner=1 busy=1", g4, own4, busy4);
        end
        set_req4(4'hF);
        tick();
    endtask

    initial begin
        set_req4(4'hF);
        set_req2(4'hF);
        test_reset();
        test_round_robin();
        test_preempt();
        test_expiry_with_release();
        test_no_contention();
        test_back_to_back();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
